tdm_demux2: RTL and testbench

Two-channel time-division demultiplexer: the receiving end of a 2:1 select-driven serial link, where an upstream mux alternates `Select` every beat to interleave two channels onto one wire. The block accepts the interleaved bit stream with a frame-sync marker and rebuilds one WIDTH-bit word per channel. It presents each completed word pair on registered outputs with a one-cycle valid strobe. It sits between the serial link and the per-channel consumers.

---
 rtl/tdm_demux2.sv | 113 +++++++++++
 tb/tb_tdm_demux2.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux2.sv
`default_nettype none
// ============================================================================
// Module      : tdm_demux2
// Description : Two-channel time-division demultiplexer. Rebuilds one
//               WIDTH-bit word per channel from an interleaved serial stream
//               (even beats -> channel 0, odd beats -> channel 1, MSB first)
//               delimited by a frame-sync marker on beat 0.
// Revision    : 1.0 - initial release
// ============================================================================
module tdm_demux2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             din,
    input  logic             sync,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic             out_valid,
    output logic             sync_err,
    output logic             busy
);

    localparam int CNT_W = $clog2(2 * WIDTH);

    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(2 * WIDTH - 1);

    localparam logic [0:0] C_IDLE = 1'b0;
    localparam logic [0:0] C_RECV = 1'b1;

    logic [0:0]       r_state;
    logic [CNT_W-1:0] r_beat_cnt;
    logic [WIDTH-1:0] r_sh0;
    logic [WIDTH-1:0] r_sh1;
    logic [WIDTH-1:0] r_out0;
    logic [WIDTH-1:0] r_out1;
    logic             r_out_valid;
    logic             r_sync_err;

    // A fresh frame starts with cleared shifters and the sync beat's bit in sh0.
    logic [WIDTH-1:0] w_sh0_start;
    assign w_sh0_start = {{(WIDTH-1){1'b0}}, din};

    // Frame state machine, shift registers and registered output words/strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= C_IDLE;
            r_beat_cnt  <= '0;
            r_sh0       <= '0;
            r_sh1       <= '0;
            r_out0      <= '0;
            r_out1      <= '0;
            r_out_valid <= 1'b0;
            r_sync_err  <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            r_sync_err  <= 1'b0;
            case (r_state)
                C_IDLE: begin
                    // Beats without a sync marker are dropped while idle.
                    if (in_valid && sync) begin
                        r_sh0      <= w_sh0_start;
                        r_sh1      <= '0;
                        r_beat_cnt <= C_CNT_ONE;
                        r_state    <= C_RECV;
                    end
                end
                C_RECV: begin
                    if (in_valid) begin
                        if (sync) begin
                            // Any sync inside a frame (final beat included)
                            // aborts it and restarts from this beat.
                            r_sync_err <= 1'b1;
                            r_sh0      <= w_sh0_start;
                            r_sh1      <= '0;
                            r_beat_cnt <= C_CNT_ONE;
                        end else if (r_beat_cnt == C_CNT_LAST) begin
                            // Final beat is odd, so its bit completes channel 1.
                            r_out0      <= r_sh0;
                            r_out1      <= {r_sh1[WIDTH-2:0], din};
                            r_out_valid <= 1'b1;
                            r_sh0       <= '0;
                            r_sh1       <= '0;
                            r_beat_cnt  <= '0;
                            r_state     <= C_IDLE;
                        end else begin
                            if (r_beat_cnt[0] == 1'b0) begin
                                r_sh0 <= {r_sh0[WIDTH-2:0], din};
                            end else begin
                                r_sh1 <= {r_sh1[WIDTH-2:0], din};
                            end
                            r_beat_cnt <= r_beat_cnt + C_CNT_ONE;
                        end
                    end
                end
                default: begin
                    r_state    <= C_IDLE;
                    r_beat_cnt <= '0;
                end
            endcase
        end
    end

    assign out0      = r_out0;
    assign out1      = r_out1;
    assign out_valid = r_out_valid;
    assign sync_err  = r_sync_err;
    assign busy      = (r_state == C_RECV);

endmodule
`default_nettype wire

// File: tb/tb_tdm_demux2.sv
`default_nettype none
// ============================================================================
// Module      : tb_tdm_demux2
// Description : Self-checking bench for tdm_demux2 (WIDTH=8). Expected word
//               pairs are queued as frames are driven and retired whenever
//               the design strobes out_valid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tdm_demux2;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         din = 1'b0;
    logic         sync = 1'b0;
    logic [W-1:0] out0;
    logic [W-1:0] out1;
    logic         out_valid;
    logic         sync_err;
    logic         busy;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int pulses = 0;
    int serr_cnt = 0;
    logic [2*W-1:0] sb[$];

    tdm_demux2 #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .din(din), .sync(sync),
        .out0(out0), .out1(out1), .out_valid(out_valid), .sync_err(sync_err),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard side: every out_valid pulse must match the oldest queued frame.
    always @(negedge clk) begin
        if (!reset && out_valid === 1'b1) begin
            logic [2*W-1:0] exp_w;
            pulses++;
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL sb_unexpected out0=%h out1=%h, no frame was expected", out0, out1);
            end else begin
                exp_w = sb.pop_front();
                if ({out0, out1} !== exp_w) begin
                    miscompares++;
                    $display("FAIL sb_words got %h/%h expected %h/%h", out0, out1, exp_w[2*W-1:W], exp_w[W-1:0]);
                end
            end
        end
        if (!reset && sync_err === 1'b1) serr_cnt++;
    end

    // One beat: inputs driven after an edge, sampled at the next, outputs read #1 later.
    task automatic beat(input logic v, input logic d, input logic s);
        in_valid = v; din = d; sync = s;
        @(posedge clk); #1;
        in_valid = 1'b0; din = 1'b0; sync = 1'b0;
    endtask

    function automatic logic fbit(input logic [W-1:0] a, input logic [W-1:0] b, input int i);
        return (i % 2 == 0) ? a[W-1-i/2] : b[W-1-i/2];
    endfunction

    task automatic send_frame(input logic [W-1:0] a, input logic [W-1:0] b);
        for (int i = 0; i < 2*W; i++) beat(1'b1, fbit(a, b, i), i == 0);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        beat(1'b0, 1'b0, 1'b0);
        beat(1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        vectors++; if (out0 !== '0) begin miscompares++; $display("FAIL rst_out0 got %h expected 00", out0); end
        vectors++; if (out1 !== '0) begin miscompares++; $display("FAIL rst_out1 got %h expected 00", out1); end
        vectors++; if ({out_valid, sync_err, busy} !== 3'b000) begin miscompares++; $display("FAIL rst_flags got %b expected 000", {out_valid, sync_err, busy}); end
    endtask

    task automatic test_basic;
        sb.push_back({8'hA5, 8'h3C});
        for (int i = 0; i < 2*W; i++) begin
            beat(1'b1, fbit(8'hA5, 8'h3C, i), i == 0);
            if (i == 0) begin
                vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL basic_busy_start got %b expected 1", busy); end
            end
            if (i == 2*W-2) begin
                vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL basic_early_valid got %b expected 0", out_valid); end
            end
        end
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL basic_valid got %b expected 1", out_valid); end
        vectors++; if ({out0, out1} !== 16'hA53C) begin miscompares++; $display("FAIL basic_words got %h/%h expected a5/3c", out0, out1); end
        vectors++; if ({sync_err, busy} !== 2'b00) begin miscompares++; $display("FAIL basic_err_busy got %b expected 00", {sync_err, busy}); end
        beat(1'b0, 1'b0, 1'b0);
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL basic_pulse_len got %b expected 0", out_valid); end
        vectors++; if ({out0, out1} !== 16'hA53C) begin miscompares++; $display("FAIL basic_hold got %h/%h expected a5/3c", out0, out1); end
    endtask

    task automatic test_gapped;
        sb.push_back({8'hA5, 8'h3C});
        for (int i = 0; i < 2*W; i++) begin
            beat(1'b1, fbit(8'hA5, 8'h3C, i), i == 0);
            if (i == 4 || i == 11) begin
                for (int g = 0; g < 3; g++) begin
                    beat(1'b0, 1'b1, 1'b1);
                    vectors++; if ({busy, out_valid} !== 2'b10) begin miscompares++; $display("FAIL gap_busy beat %0d got busy/valid %b expected 10", i, {busy, out_valid}); end
                end
            end
        end
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL gap_valid got %b expected 1", out_valid); end
        beat(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back;
        int t1, t2;
        t1 = 0;
        sb.push_back({8'hFF, 8'h00});
        sb.push_back({8'h0F, 8'hF0});
        send_frame(8'hFF, 8'h00);
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_valid1 got %b expected 1", out_valid); end
        t1 = cyc;
        send_frame(8'h0F, 8'hF0);
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_valid2 got %b expected 1", out_valid); end
        t2 = cyc;
        vectors++; if (t2 - t1 !== 2*W) begin miscompares++; $display("FAIL b2b_spacing got %0d expected %0d", t2 - t1, 2*W); end
        beat(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_resync;
        int e0;
        e0 = serr_cnt;
        for (int i = 0; i < 6; i++) beat(1'b1, 1'b1, i == 0);
        sb.push_back({8'h12, 8'h34});
        for (int i = 0; i < 2*W; i++) begin
            beat(1'b1, fbit(8'h12, 8'h34, i), i == 0);
            if (i == 0) begin
                vectors++; if ({sync_err, busy} !== 2'b11) begin miscompares++; $display("FAIL resync_err got err/busy %b expected 11", {sync_err, busy}); end
            end
            if (i == 1) begin
                vectors++; if (sync_err !== 1'b0) begin miscompares++; $display("FAIL resync_err_len got %b expected 0", sync_err); end
            end
        end
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL resync_valid got %b expected 1", out_valid); end
        beat(1'b0, 1'b0, 1'b0);
        vectors++; if (serr_cnt - e0 !== 1) begin miscompares++; $display("FAIL resync_err_count got %0d expected 1", serr_cnt - e0); end
    endtask

    task automatic test_sync_final;
        for (int i = 0; i < 2*W-1; i++) beat(1'b1, fbit(8'hC3, 8'h96, i), i == 0);
        sb.push_back({8'h55, 8'hAA});
        beat(1'b1, fbit(8'h55, 8'hAA, 0), 1'b1);
        vectors++; if ({out_valid, sync_err, busy} !== 3'b011) begin miscompares++; $display("FAIL final_sync got valid/err/busy %b expected 011", {out_valid, sync_err, busy}); end
        for (int i = 1; i < 2*W; i++) beat(1'b1, fbit(8'h55, 8'hAA, i), 1'b0);
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL final_restart_valid got %b expected 1", out_valid); end
        beat(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_nosync_reset;
        int p0;
        p0 = pulses;
        for (int i = 0; i < 20; i++) begin
            beat(1'b1, 1'($urandom_range(0, 1)), 1'b0);
        end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL nosync_busy got %b expected 0", busy); end
        vectors++; if (pulses !== p0) begin miscompares++; $display("FAIL nosync_pulses got %0d expected %0d", pulses, p0); end
        for (int i = 0; i < 9; i++) beat(1'b1, fbit(8'hE7, 8'h5A, i), i == 0);
        reset = 1'b1;
        beat(1'b1, fbit(8'hE7, 8'h5A, 9), 1'b0);
        reset = 1'b0;
        vectors++; if ({out0, out1} !== 16'h0000) begin miscompares++; $display("FAIL midrst_words got %h/%h expected 00/00", out0, out1); end
        vectors++; if ({out_valid, sync_err, busy} !== 3'b000) begin miscompares++; $display("FAIL midrst_flags got %b expected 000", {out_valid, sync_err, busy}); end
        sb.push_back({8'h81, 8'h7E});
        send_frame(8'h81, 8'h7E);
        vectors++; if ({out_valid, out0, out1} !== {1'b1, 16'h817E}) begin miscompares++; $display("FAIL clean_frame got %b %h/%h expected 1 81/7e", out_valid, out0, out1); end
        beat(1'b0, 1'b0, 1'b0);
        vectors++; if (pulses - p0 !== 1) begin miscompares++; $display("FAIL clean_pulse_count got %0d expected 1", pulses - p0); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gapped();
        test_back_to_back();
        test_resync();
        test_sync_final();
        test_nosync_reset();
        beat(1'b0, 1'b0, 1'b0);
        beat(1'b0, 1'b0, 1'b0);
        vectors++; if (sb.size() != 0) begin miscompares++; $display("FAIL sb_leftover got %0d frames expected 0", sb.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
